// File: rtl/execute_mem_stage.sv
// Execute stage of the 5-stage MIPS pipeline fused with the EX/MEM register.
// Computes the ALU result, publishes E-stage hazard info, and registers results toward Memory.
module execute_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] e_pc,
    input  logic [31:0] e_instr,
    input  logic [31:0] e_rs_data,
    input  logic [31:0] e_rt_data,
    input  logic [31:0] e_ext,
    input  logic [31:0] e_shift,
    output logic [1:0]  e_tnew,
    output logic [4:0]  e_regwreg,
    output logic [31:0] e_regwd,
    output logic        e_regwrite,
    output logic [31:0] m_pc,
    output logic [31:0] m_instr,
    output logic [31:0] m_aluout,
    output logic [31:0] m_rt_data,
    output logic [31:0] m_shift
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [31:0] alu_result;
    logic        is_writer;
    logic [4:0]  wr_dest;
    logic [1:0]  wr_tnew;
    logic        writes_gpr;

    // The rs field is not decoded here: its value arrives already forwarded.
    logic unused_rs_field;
    assign unused_rs_field = ^e_instr[25:21];

    assign op       = e_instr[31:26];
    assign funct    = e_instr[5:0];
    assign rt_field = e_instr[20:16];
    assign rd_field = e_instr[15:11];

    always_comb begin
        alu_result = 32'h0;
        is_writer  = 1'b0;
        wr_dest    = 5'd0;
        wr_tnew    = 2'd0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin
                        alu_result = e_rs_data + e_rt_data;
                        is_writer  = 1'b1;
                        wr_dest    = rd_field;
                        wr_tnew    = 2'd1;
                    end
                    FN_SUBU: begin
                        alu_result = e_rs_data - e_rt_data;
                        is_writer  = 1'b1;
                        wr_dest    = rd_field;
                        wr_tnew    = 2'd1;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                alu_result = e_rs_data | e_ext;
                is_writer  = 1'b1;
                wr_dest    = rt_field;
                wr_tnew    = 2'd1;
            end
            OP_LUI: begin
                alu_result = {e_instr[15:0], 16'h0000};
                is_writer  = 1'b1;
                wr_dest    = rt_field;
                wr_tnew    = 2'd1;
            end
            OP_LW: begin
                alu_result = e_rs_data + e_ext;
                is_writer  = 1'b1;
                wr_dest    = rt_field;
                wr_tnew    = 2'd2;
            end
            OP_SW: begin
                alu_result = e_rs_data + e_ext;
            end
            OP_JAL: begin
                alu_result = e_pc + 32'd8;
                is_writer  = 1'b1;
                wr_dest    = 5'd31;
                wr_tnew    = 2'd0;
            end
            default: ;
        endcase
    end

    // Writes to $0 are squashed so the hazard unit never sees them.
    assign writes_gpr = is_writer && (wr_dest != 5'd0);
    assign e_regwrite = writes_gpr;
    assign e_regwreg  = writes_gpr ? wr_dest : 5'd0;
    assign e_tnew     = writes_gpr ? wr_tnew : 2'd0;
    assign e_regwd    = alu_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc      <= 32'h0;
            m_instr   <= 32'h0;
            m_aluout  <= 32'h0;
            m_rt_data <= 32'h0;
            m_shift   <= 32'h0;
        end else begin
            m_pc      <= e_pc;
            m_instr   <= e_instr;
            m_aluout  <= alu_result;
            m_rt_data <= e_rt_data;
            m_shift   <= e_shift;
        end
    end

endmodule

// File: tb/tb_execute_mem_stage.sv
// Self-checking bench for execute_mem_stage: rule-level model, per-cycle compare,
// and directed vectors with hand-computed expectations.
module tb_execute_mem_stage;

    logic        clk;
    logic        reset;
    logic [31:0] e_pc, e_instr, e_rs_data, e_rt_data, e_ext, e_shift;
    logic [1:0]  e_tnew;
    logic [4:0]  e_regwreg;
    logic [31:0] e_regwd;
    logic        e_regwrite;
    logic [31:0] m_pc, m_instr, m_aluout, m_rt_data, m_shift;

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    execute_mem_stage dut (
        .clk       (clk),
        .reset     (reset),
        .e_pc      (e_pc),
        .e_instr   (e_instr),
        .e_rs_data (e_rs_data),
        .e_rt_data (e_rt_data),
        .e_ext     (e_ext),
        .e_shift   (e_shift),
        .e_tnew    (e_tnew),
        .e_regwreg (e_regwreg),
        .e_regwd   (e_regwd),
        .e_regwrite(e_regwrite),
        .m_pc      (m_pc),
        .m_instr   (m_instr),
        .m_aluout  (m_aluout),
        .m_rt_data (m_rt_data),
        .m_shift   (m_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic        we;
        logic [4:0]  dest;
        logic [1:0]  tnew;
    } exp_t;

    // Instruction semantics straight from the ISA table: result, then hazard info.
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [31:0] ext);
        exp_t r;
        int   op, fn, dest, tnew;
        op   = int'(instr[31:26]);
        fn   = int'(instr[5:0]);
        dest = -1;
        tnew = 0;
        r    = '0;
        if (op == 0 && fn == 'h21) begin r.alu = rs + rt; dest = int'(instr[15:11]); tnew = 1; end
        else if (op == 0 && fn == 'h23) begin r.alu = rs - rt; dest = int'(instr[15:11]); tnew = 1; end
        else if (op == 'h0D) begin r.alu = rs | ext; dest = int'(instr[20:16]); tnew = 1; end
        else if (op == 'h0F) begin r.alu = instr[15:0] * 32'd65536; dest = int'(instr[20:16]); tnew = 1; end
        else if (op == 'h23) begin r.alu = rs + ext; dest = int'(instr[20:16]); tnew = 2; end
        else if (op == 'h2B) begin r.alu = rs + ext; end
        else if (op == 'h03) begin r.alu = pc + 8; dest = 31; tnew = 0; end
        if (dest > 0) begin
            r.we   = 1'b1;
            r.dest = dest[4:0];
            r.tnew = tnew[1:0];
        end
        return r;
    endfunction

    // Expected EX/MEM contents: whatever sat at E on the last edge, or zeros under reset.
    logic [31:0] x_pc, x_instr, x_alu, x_rt, x_shift;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_pc <= '0; x_instr <= '0; x_alu <= '0; x_rt <= '0; x_shift <= '0;
        end else begin
            x_pc    <= e_pc;
            x_instr <= e_instr;
            x_alu   <= model(e_instr, e_pc, e_rs_data, e_rt_data, e_ext).alu;
            x_rt    <= e_rt_data;
            x_shift <= e_shift;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    exp_t cm;
    always @(negedge clk) begin
        if (cmp_en) begin
            cm = model(e_instr, e_pc, e_rs_data, e_rt_data, e_ext);
            chk("cyc_regwd",    e_regwd,            cm.alu);
            chk("cyc_regwrite", {31'd0, e_regwrite}, {31'd0, cm.we});
            chk("cyc_regwreg",  {27'd0, e_regwreg},  {27'd0, cm.dest});
            chk("cyc_tnew",     {30'd0, e_tnew},     {30'd0, cm.tnew});
            chk("cyc_m_pc",     m_pc,      x_pc);
            chk("cyc_m_instr",  m_instr,   x_instr);
            chk("cyc_m_aluout", m_aluout,  x_alu);
            chk("cyc_m_rt",     m_rt_data, x_rt);
            chk("cyc_m_shift",  m_shift,   x_shift);
        end
    end

    task automatic apply(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ext, input logic [31:0] sh);
        @(posedge clk);
        #1;
        e_pc = pc; e_instr = instr; e_rs_data = rs; e_rt_data = rt; e_ext = ext; e_shift = sh;
        $display("txn pc=%h instr=%h rs=%h rt=%h ext=%h shift=%h", pc, instr, rs, rt, ext, sh);
        #1;
    endtask

    task automatic chk_e(input string name, input logic [31:0] wd, input logic [4:0] wreg,
                         input logic [1:0] tnew, input logic we);
        chk({name, "_regwd"},    e_regwd, wd);
        chk({name, "_regwreg"},  {27'd0, e_regwreg}, {27'd0, wreg});
        chk({name, "_tnew"},     {30'd0, e_tnew}, {30'd0, tnew});
        chk({name, "_regwrite"}, {31'd0, e_regwrite}, {31'd0, we});
    endtask

    localparam logic [31:0] I_ADDU = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    localparam logic [31:0] I_SUBU = {6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h23};
    localparam logic [31:0] I_ORI  = {6'h0D, 5'd0, 5'd5, 16'h000F};
    localparam logic [31:0] I_LUI  = {6'h0F, 5'd0, 5'd4, 16'h1234};
    localparam logic [31:0] I_LW   = {6'h23, 5'd9, 5'd8, 16'h0004};
    localparam logic [31:0] I_SW   = {6'h2B, 5'd9, 5'd8, 16'h0008};
    localparam logic [31:0] I_JAL  = {6'h03, 26'h0000C04};
    localparam logic [31:0] I_BEQ  = {6'h04, 5'd1, 5'd2, 16'h0006};
    localparam logic [31:0] I_JR   = {6'h00, 5'd31, 15'd0, 6'h08};
    localparam logic [31:0] I_ORI0 = {6'h0D, 5'd1, 5'd0, 16'hFFFF};
    localparam logic [31:0] I_BAD  = {6'h3F, 26'h1234567};

    initial begin
        #200000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        e_pc = '0; e_instr = '0; e_rs_data = '0; e_rt_data = '0; e_ext = '0; e_shift = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_instr", m_instr, 32'h0);
        chk("rst_m_aluout", m_aluout, 32'h0);
        #1;
        reset = 1'b1;
        cmp_en = 1'b1;

        // Populate EX/MEM with non-zero content, then assert reset mid-cycle.
        apply(32'h00003000, I_SUBU, 32'h00000007, 32'h00000003, 32'h0, 32'h00003100);
        apply(32'h00003004, I_LW, 32'h00001000, 32'h55555555, 32'h4, 32'h00003104);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_m_pc",      m_pc,      32'h0);
        chk("midrst_m_instr",   m_instr,   32'h0);
        chk("midrst_m_aluout",  m_aluout,  32'h0);
        chk("midrst_m_rt_data", m_rt_data, 32'h0);
        chk("midrst_m_shift",   m_shift,   32'h0);
        @(posedge clk);
        #1;
        chk("heldrst_m_instr", m_instr, 32'h0);
        #1;
        reset = 1'b1;

        apply(32'h00003008, I_ADDU, 32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0);
        chk_e("addu", 32'h00000001, 5'd3, 2'd1, 1'b1);
        @(posedge clk);
        #1;
        chk("addu_m_aluout", m_aluout, 32'h00000001);
        chk("addu_m_instr",  m_instr,  I_ADDU);
        chk("addu_m_pc",     m_pc,     32'h00003008);

        apply(32'h0000300C, I_SUBU, 32'h0, 32'h1, 32'h0, 32'h0);
        chk_e("subu", 32'hFFFFFFFF, 5'd6, 2'd1, 1'b1);

        apply(32'h00003010, I_ORI, 32'h0000F000, 32'h0, 32'h0000000F, 32'h0);
        chk_e("ori", 32'h0000F00F, 5'd5, 2'd1, 1'b1);

        apply(32'h00003014, I_LUI, 32'hAAAAAAAA, 32'h0, 32'hDEADBEEF, 32'h0);
        chk_e("lui", 32'h12340000, 5'd4, 2'd1, 1'b1);

        apply(32'h00003018, I_LW, 32'h00001000, 32'h0, 32'h00000004, 32'h0);
        chk_e("lw", 32'h00001004, 5'd8, 2'd2, 1'b1);

        apply(32'h0000301C, I_SW, 32'h00001000, 32'hCAFEBABE, 32'h00000008, 32'h0);
        chk_e("sw", 32'h00001008, 5'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("sw_m_rt_data", m_rt_data, 32'hCAFEBABE);

        apply(32'h00003010, I_JAL, 32'h0, 32'h0, 32'h0, 32'h00003010);
        chk_e("jal", 32'h00003018, 5'd31, 2'd0, 1'b1);

        apply(32'h00003020, I_BEQ, 32'h5, 32'h5, 32'h6, 32'h0000302C);
        chk_e("beq", 32'h0, 5'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("beq_m_shift", m_shift, 32'h0000302C);

        apply(32'h00003024, I_JR, 32'h00003040, 32'h0, 32'h0, 32'h00003040);
        chk_e("jr", 32'h0, 5'd0, 2'd0, 1'b0);

        apply(32'h00003028, I_ORI0, 32'h00000001, 32'h0, 32'h0000FFFF, 32'h0);
        chk_e("ori0", 32'h0000FFFF, 5'd0, 2'd0, 1'b0);

        apply(32'h0000302C, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h11111111, 32'h0);
        chk_e("nop", 32'h0, 5'd0, 2'd0, 1'b0);

        apply(32'h00003030, I_BAD, 32'h12345678, 32'h1, 32'h2, 32'h3);
        chk_e("unlisted", 32'h0, 5'd0, 2'd0, 1'b0);

        // Back-to-back stream; the per-cycle compare tracks each one through EX/MEM.
        for (int i = 0; i < 12; i++) begin
            logic [31:0] instr;
            case (i % 6)
                0: instr = I_ADDU;
                1: instr = I_LW;
                2: instr = I_SUBU;
                3: instr = I_SW;
                4: instr = I_JAL;
                default: instr = I_ORI;
            endcase
            apply(32'h00004000 + 32'(i * 4), instr, $urandom, $urandom, $urandom, $urandom);
        end
        @(posedge clk);
        #1;
        chk("stream_last_instr", m_instr, I_ORI);
        chk("stream_last_pc",    m_pc,    32'h0000402C);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
